// File: rtl/crossbar_rr_switch.sv
// crossbar_rr_switch: N x M packet crossbar with a registered slot and a round-robin arbiter per output,
// plus a per-input destination mask; denied packets are consumed, dropped and counted.
module crossbar_rr_switch #(
    parameter int N  = 4,
    parameter int M  = 4,
    parameter int DW = 32,
    localparam int DESTW = $clog2(M),
    localparam int SRCW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      in_valid,
    input  logic [N*DESTW-1:0] in_dest,
    input  logic [N*DW-1:0]   in_data,
    output logic [N-1:0]      in_ready,
    output logic [M-1:0]      out_valid,
    output logic [M*DW-1:0]   out_data,
    output logic [M*SRCW-1:0] out_src,
    input  logic [M-1:0]      out_ready,
    input  logic              cfg_we,
    input  logic [SRCW-1:0]   cfg_idx,
    input  logic [M-1:0]      cfg_mask,
    output logic [N-1:0]      deny,
    output logic [15:0]       deny_cnt
);
    logic [M-1:0]      mask_q [N];
    logic [SRCW-1:0]   ptr_q [M];
    logic [M-1:0]      out_valid_q;
    logic [M*DW-1:0]   out_data_q;
    logic [M*SRCW-1:0] out_src_q;
    logic [N-1:0]      deny_q;
    logic [15:0]       deny_cnt_q;
    logic [16:0]       cnt_sum_d;
    logic [N-1:0]      allowed, denied;
    logic [M-1:0]      free, grant;
    logic [SRCW-1:0]   win [M];
    logic [SRCW-1:0]   idx;

    assign free      = ~out_valid_q | out_ready;
    assign cnt_sum_d = {1'b0, deny_cnt_q} + 17'($countones(denied));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            allowed[i] = int'(in_dest[i*DESTW +: DESTW]) < M && mask_q[i][in_dest[i*DESTW +: DESTW]];
            denied[i]  = in_valid[i] && !allowed[i];
        end
    end

    // Denied packets are consumed immediately so a blocked input never stalls.
    always_comb begin
        grant    = '0;
        in_ready = denied;
        idx      = '0;
        for (int j = 0; j < M; j++) begin
            win[j] = '0;
            for (int k = 0; k < N; k++) begin
                idx = SRCW'((int'(ptr_q[j]) + k) % N);
                if (free[j] && !grant[j] && in_valid[idx] && allowed[idx] &&
                    int'(in_dest[idx*DESTW +: DESTW]) == j) begin
                    grant[j] = 1'b1;
                    win[j]   = idx;
                end
            end
            if (grant[j]) in_ready[win[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mask_q[i] <= '1;
            for (int j = 0; j < M; j++) ptr_q[j] <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            deny_q      <= '0;
            deny_cnt_q  <= '0;
        end else begin
            if (cfg_we && int'(cfg_idx) < N) mask_q[cfg_idx] <= cfg_mask;
            for (int j = 0; j < M; j++) begin
                if (grant[j]) begin
                    out_valid_q[j]              <= 1'b1;
                    out_data_q[j*DW +: DW]      <= in_data[win[j]*DW +: DW];
                    out_src_q[j*SRCW +: SRCW]   <= win[j];
                    ptr_q[j]                    <= SRCW'((int'(win[j]) + 1) % N);
                end else if (out_ready[j]) begin
                    out_valid_q[j] <= 1'b0;
                end
            end
            deny_q     <= denied;
            deny_cnt_q <= cnt_sum_d[16] ? 16'hFFFF : cnt_sum_d[15:0];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign deny      = deny_q;
    assign deny_cnt  = deny_cnt_q;
endmodule
